// File: rtl/conv_pkg.sv
// Shared constants and FSM state encoding for the fixed-to-float converter.
//   FP_BIAS   : IEEE-754 single-precision exponent bias
//   FP_MANT_W : stored mantissa width
//   FP_EXP_W  : exponent field width
//   Q_FRAC_W  : fractional bits of the Q1.31 input
package conv_pkg;

  localparam int unsigned FP_BIAS   = 127;
  localparam int unsigned FP_MANT_W = 23;
  localparam int unsigned FP_EXP_W  = 8;
  localparam int unsigned Q_FRAC_W  = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/conv_round_pack.sv
// Combinational rounding and IEEE-754 single-precision packing of a
// normalized magnitude.
// Configuration macro: CONV_ROUND_RNE_EN
//   defined   -> round to nearest, ties to even (guard/sticky/LSB)
//   undefined -> truncate
// Ports:
//   sign_i   : sign of the operand
//   exp_i    : biased exponent matching mag_i
//   mag_i    : magnitude, normalized so bit 31 is set (or all zero)
//   result_o : packed float; +0.0 when mag_i is zero
module conv_round_pack
  import conv_pkg::*;
(
  input  logic                  sign_i,
  input  logic [FP_EXP_W-1:0]   exp_i,
  input  logic [Q_FRAC_W:0]     mag_i,
  output logic [31:0]           result_o
);

  logic [FP_MANT_W-1:0] mant;
  logic [FP_MANT_W-1:0] mant_r;
  logic                 carry;
  logic                 round_up;
  logic [FP_EXP_W-1:0]  exp_r;
`ifdef CONV_ROUND_RNE_EN
  logic                 guard;
  logic                 sticky;
`endif

  always_comb begin
    mant = mag_i[30:8];
`ifdef CONV_ROUND_RNE_EN
    guard    = mag_i[7];
    sticky   = |mag_i[6:0];
    round_up = guard & (sticky | mant[0]);
`else
    round_up = 1'b0;
`endif
    // Mantissa overflow from rounding wraps to zero and bumps the exponent.
    {carry, mant_r} = {1'b0, mant} + {{FP_MANT_W{1'b0}}, round_up};
    exp_r = exp_i + {{(FP_EXP_W-1){1'b0}}, carry};
    if (mag_i == '0) begin
      result_o = '0;
    end else begin
      result_o = {sign_i, exp_r, mant_r};
    end
  end

endmodule

// File: rtl/fix_to_fp_seq.sv
// Sequential Q1.31 fixed-point to IEEE-754 single-precision converter.
// Normalizes one bit per cycle (latency = leading zeros + 3 edges).
// Configuration macro: CONV_ROUND_RNE_EN (rounding mode, see conv_round_pack).
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset, overrides clk_en
//   clk_en : low holds all state
//   start  : one-cycle request, accepted only in IDLE
//   dataa  : signed Q1.31 operand
//   done   : one-cycle result-valid strobe
//   result : float equal to dataa * 2^-31, held until the next conversion
module fix_to_fp_seq
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result
);

  state_e              state_q;
  logic                sign_q;
  logic [Q_FRAC_W:0]   mag_q;
  logic [FP_EXP_W-1:0] exp_q;
  logic                done_q;
  logic [31:0]         result_q;

  logic [Q_FRAC_W:0]   abs_d;
  logic [31:0]         packed_d;

  // Two's-complement negation leaves 0x80000000 as 2^31, which is exactly
  // the unsigned magnitude of -1.0.
  assign abs_d = dataa[31] ? (~dataa + 32'd1) : dataa;

  conv_round_pack u_round_pack (
    .sign_i   (sign_q),
    .exp_i    (exp_q),
    .mag_i    (mag_q),
    .result_o (packed_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      exp_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (clk_en) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sign_q  <= dataa[31];
            mag_q   <= abs_d;
            exp_q   <= FP_EXP_W'(FP_BIAS);
            state_q <= NORM;
          end
        end
        NORM: begin
          if (mag_q[Q_FRAC_W] || (mag_q == '0)) begin
            state_q <= PACK;
          end else begin
            mag_q <= {mag_q[Q_FRAC_W-1:0], 1'b0};
            exp_q <= exp_q - 8'd1;
          end
        end
        PACK: begin
          result_q <= packed_d;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_fix_to_fp_seq.sv
// Self-checking bench for fix_to_fp_seq. Expected results and latencies are
// queued when a request is issued and popped when done is observed.
module tb_fix_to_fp_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic        done;
  logic [31:0] result;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] last_result = '0;

  typedef struct {
    logic [31:0] din;
    logic [31:0] want;
    int          lat;
  } txn_t;

  txn_t sb[$];

  always #5 clk = ~clk;

  fix_to_fp_seq dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .done   (done),
    .result (result)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: locate the leading one, take 24 significant bits, round the
  // 8 dropped bits against the halfway value 0x80.
  function automatic logic [31:0] ref_conv(input logic [31:0] d);
    logic [31:0] m;
    logic [31:0] v;
    logic [23:0] frac;
    logic [7:0]  low;
    logic [7:0]  e;
    logic        rnd;
    int          p;
    m = d[31] ? (~d + 32'd1) : d;
    if (m == 32'd0) return 32'd0;
    p = 31;
    while (m[p] == 1'b0) p--;
    e    = 8'(96 + p);
    v    = m << (31 - p);
    frac = v[31:8];
    low  = v[7:0];
`ifdef CONV_ROUND_RNE_EN
    rnd = (low > 8'h80) || ((low == 8'h80) && frac[0]);
`else
    rnd = 1'b0;
`endif
    if (rnd) begin
      if (frac == 24'hFFFFFF) begin
        frac = 24'h800000;
        e    = e + 8'd1;
      end else begin
        frac = frac + 24'd1;
      end
    end
    return {d[31], e, frac[22:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] d);
    logic [31:0] m;
    int lz;
    m = d[31] ? (~d + 32'd1) : d;
    if (m == 32'd0) return 3;
    lz = 0;
    while (m[31 - lz] == 1'b0) lz++;
    return lz + 3;
  endfunction

  // Drives one start pulse (sampled on edge 1) and queues the expectation.
  task automatic push_start(input logic [31:0] d, input logic [31:0] want, input int lat);
    txn_t t;
    t.din  = d;
    t.want = want;
    t.lat  = lat;
    sb.push_back(t);
    dataa = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for done; returns the edge count at which it was seen.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < 80) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    clk_en = 1'b0;
    start  = 1'b0;
    dataa  = '0;
    tick();
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %b want 0", done);
    end
    checks++;
    if (result !== 32'h0) begin
      errors++;
      $display("FAIL reset_result got %h want 00000000", result);
    end
    reset  = 1'b0;
    clk_en = 1'b1;
    tick();
  endtask

  task automatic test_table();
    logic [31:0] din  [7];
    logic [31:0] want [7];
    int          lat  [7];
    txn_t t;
    int n;
    din[0] = 32'h40000000; want[0] = 32'h3F000000; lat[0] = 4;
    din[1] = 32'h7054A42F; want[1] = 32'h3F60A948; lat[1] = 4;
    din[2] = 32'hC0000000; want[2] = 32'hBF000000; lat[2] = 4;
    din[3] = 32'h80000000; want[3] = 32'hBF800000; lat[3] = 3;
`ifdef CONV_ROUND_RNE_EN
    din[4] = 32'h7FFFFFFF; want[4] = 32'h3F800000; lat[4] = 4;
`else
    din[4] = 32'h7FFFFFFF; want[4] = 32'h3F7FFFFF; lat[4] = 4;
`endif
    din[5] = 32'h00000000; want[5] = 32'h00000000; lat[5] = 3;
    din[6] = 32'h00000001; want[6] = 32'h30000000; lat[6] = 34;
    for (int i = 0; i < 7; i++) begin
      push_start(din[i], want[i], lat[i]);
      wait_done(1, n);
      t = sb.pop_front();
      checks++;
      if (result !== t.want) begin
        errors++;
        $display("FAIL table_result din=%h got %h want %h", t.din, result, t.want);
      end
      checks++;
      if (n != t.lat) begin
        errors++;
        $display("FAIL table_latency din=%h got %0d want %0d", t.din, n, t.lat);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL table_done_pulse din=%h got %b want 0", t.din, done);
      end
      last_result = t.want;
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    txn_t t;
    int n;
    for (int i = 0; i < 10; i++) begin
      d = $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) d = ~d + 32'd1;
      push_start(d, ref_conv(d), ref_lat(d));
      wait_done(1, n);
      t = sb.pop_front();
      checks++;
      if (result !== t.want || n != t.lat) begin
        errors++;
        $display("FAIL random din=%h got %h@%0d want %h@%0d", t.din, result, n, t.want, t.lat);
      end
      tick();
      last_result = t.want;
    end
  endtask

  task automatic test_hold();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (result !== last_result || seen) begin
      errors++;
      $display("FAIL hold got %h done_seen=%b want %h done_seen=0", result, seen, last_result);
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    seen  = 1'b0;
    dataa = 32'h00000001;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 2; i <= 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_done got 1 want 0");
    end
    checks++;
    if (result !== 32'h0) begin
      errors++;
      $display("FAIL abort_result got %h want 00000000", result);
    end
  endtask

  task automatic test_stall();
    txn_t t;
    int n;
    push_start(32'h00000001, 32'h30000000, 34 + 5);
    for (int i = 2; i <= 5; i++) tick();
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    clk_en = 1'b1;
    wait_done(10, n);
    t = sb.pop_front();
    checks++;
    if (n != t.lat) begin
      errors++;
      $display("FAIL stall_latency got %0d want %0d", n, t.lat);
    end
    checks++;
    if (result !== t.want) begin
      errors++;
      $display("FAIL stall_result got %h want %h", result, t.want);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    txn_t t;
    int n;
    logic seen;
    push_start(32'h40000000, 32'h3F000000, 4);
    dataa = 32'h7FFFFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(2, n);
    t = sb.pop_front();
    checks++;
    if (result !== t.want || n != t.lat) begin
      errors++;
      $display("FAIL ignore_start got %h@%0d want %h@%0d", result, n, t.want, t.lat);
    end
    seen = 1'b0;
    tick();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL ignore_start_queued got done=1 want no second done");
    end
  endtask

  initial begin
    test_reset();
    test_table();
    test_random();
    test_hold();
    test_reset_abort();
    test_stall();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fix_to_fp_seq.md
FIX_TO_FP_SEQ -- requirements
Module: fix_to_fp_seq

Interface
REQ-001 SHALL expose: clk  input  1  sole clock, rising edge.
REQ-002 SHALL expose: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL expose: clk_en  input  1  stall control; low holds all state.
REQ-004 SHALL expose: start  input  1  single-cycle request, sampled with clk_en=1.
REQ-005 SHALL expose: dataa  input  32  signed Q1.31 operand, range [-1.0, 1.0).
REQ-006 SHALL expose: done  output  1  result-valid strobe.
REQ-007 SHALL expose: result  output  32  IEEE-754 single-precision result.
REQ-008 SHALL have no parameters; all widths are fixed.

Function
REQ-009 SHALL convert dataa to the float equal to dataa*2^-31. The conversion is the inverse of the team's fp_to_int.
REQ-010 SHALL take the sign from dataa[31] and the magnitude mag as a 32-bit unsigned value. 0x80000000 gives mag=2^31.
REQ-011 SHALL use these states: IDLE, NORM, PACK, DONE.
REQ-012 IDLE: on an edge with start=1, SHALL latch sign and mag, set exp=127, and enter NORM.
REQ-013 NORM: on each edge, if mag[31]=1 or mag=0, SHALL enter PACK. Otherwise SHALL shift mag left by 1 and decrement exp.
REQ-014 PACK: SHALL form mantissa=mag[30:8], guard=mag[7] and sticky=OR(mag[6:0]), round per REQ-024, register result, then enter DONE.
REQ-015 DONE: done SHALL be 1 for exactly one enabled cycle, then the block SHALL return to IDLE.
REQ-016 Latency SHALL be lz+3 rising edges from the start-sampling edge to done high, where lz is the leading-zero count of mag. mag=0 SHALL count as lz=0.
REQ-017 mag=0 SHALL give result 0x00000000, never negative zero.
REQ-018 A mantissa carry from rounding SHALL clear the mantissa and increment exp.
REQ-019 The output SHALL never be denormal, infinite or NaN. The minimum exponent is 96.
REQ-020 start outside IDLE SHALL be ignored, with no queuing.
REQ-021 With clk_en=0, state, counters, done and result SHALL all hold.
REQ-022 result SHALL hold its last completed value until the next PACK.

Reset
REQ-023 With reset=1 on a rising edge, state SHALL become IDLE and done=0 and result=0x00000000, regardless of clk_en or any operation in flight. An aborted conversion SHALL never produce done.

Configuration
REQ-024 Macro CONV_ROUND_RNE_EN:
- Defined: SHALL round to nearest, ties to even, using guard, sticky and mantissa LSB.
- Undefined: SHALL truncate (guard and sticky ignored).
- Latency SHALL be identical in both cases.

Structure
REQ-025 SHALL take from the shared package conv_pkg:
- the state encoding;
- FP_BIAS=127;
- FP_MANT_W=23;
- FP_EXP_W=8;
- Q_FRAC_W=31.
REQ-026 Rounding and packing SHALL live in one combinational sub-module, conv_round_pack, which holds the REQ-024 macro. The FSM and normalizer SHALL stay in fix_to_fp_seq.

Verification
REQ-027 The bench SHALL cover these scenarios:
- 0x40000000 -> 0x3F000000; done on edge 4 after start.
- 0x7054A42F -> 0x3F60A948 in both rounding modes. 0xC0000000 -> 0xBF000000.
- 0x80000000 -> 0xBF800000; done on edge 3 (lz=0).
- 0x7FFFFFFF -> 0x3F800000 with CONV_ROUND_RNE_EN, 0x3F7FFFFF without.
- 0x00000000 -> 0x00000000 on edge 3. 0x00000001 -> 0x30000000 on edge 34.
- start 0x00000001, reset on edge 10 -> done stays 0 and result=0. clk_en low for 5 cycles mid-NORM -> done delayed exactly 5 cycles. start pulsed in NORM -> ignored.
